csr_reg: RTL

Machine-mode CSR register file sitting directly downstream of the core-local interrupt controller (clint). It holds mstatus, mie, mtvec, mscratch, mepc, mcause, misa, the privilege level and an optional 64-bit cycle counter. It arbitrates CSR writes from the clint and from the execute stage, and serves two combinational read ports. It drives the mtvec/mepc/mstatus snapshot that the clint consumes.

---
 rtl/csr_reg_pkg.sv | 32 +++
 rtl/csr_counter64.sv | 31 +++
 rtl/csr_reg.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/csr_reg_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, privilege
// encodings, mstatus field positions, write masks and reset values.
package csr_reg_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

  localparam logic [1:0] PRIVILEG_MACHINE  = 2'b11;
  localparam logic [1:0] PRIVILEG_USER     = 2'b00;
  localparam logic [1:0] PRIVILEG_RESERVED = 2'b10;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;

  localparam logic [31:0] MSTATUS_WR_MASK = (32'd1 << MSTATUS_MIE_BIT)
                                          | (32'd1 << MSTATUS_MPIE_BIT)
                                          | (32'd3 << MSTATUS_MPP_LO);
  localparam logic [31:0] MIE_WR_MASK     = 32'h0000_0888;
  localparam logic [31:0] MISA_VALUE      = 32'h4000_1100;
  localparam logic [31:0] MSTATUS_RST     = {19'd0, PRIVILEG_MACHINE, 11'd0};

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running cycle counter with independent low/high word loads.
// A low-word load freezes the high word for that cycle; a high-word load
// lets the low word keep counting but discards its carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_lo_i,
  input  logic        load_hi_i,
  input  logic [31:0] load_data_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;

  // Count, or load one word while handling the other as described above
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_lo_i) begin
      count_q[31:0] <= load_data_i;
    end else if (load_hi_i) begin
      count_q[63:32] <= load_data_i;
      count_q[31:0]  <= count_q[31:0] + 32'd1;
    end else begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR register file behind the clint. Arbitrates clint and
// execute-stage writes (clint wins), serves two combinational read ports
// with same-cycle write forwarding, and exports registered views to clint.
// Build option: CSR_CYCLE_COUNTER_EN adds the 64-bit mcycle/cycle counter.
module csr_reg
  import csr_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wr_en_i,
  input  logic [31:0] ex_wr_addr_i,
  input  logic [31:0] ex_wr_data_i,
  input  logic [31:0] ex_rd_addr_i,
  output logic [31:0] ex_rd_data_o,
  input  logic        clint_wr_en_i,
  input  logic [31:0] clint_wr_addr_i,
  input  logic [31:0] clint_wr_data_i,
  input  logic [31:0] clint_rd_addr_i,
  output logic [31:0] clint_rd_data_o,
  input  logic        wr_privilege_en_i,
  input  logic [1:0]  wr_privilege_i,
  output logic [1:0]  privilege_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o,
  output logic        global_int_en_o
);

  logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [1:0]  priv_q;
  logic [63:0] cycle_q;

  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        fwd_ok;
  logic        fwd_hit;
  logic [31:0] fwd_val;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ex_wr_addr_i[31:12], clint_wr_addr_i[31:12],
                              ex_rd_addr_i[31:12], clint_rd_addr_i[31:12]};

  // Only MIE/MPIE/MPP survive; the reserved MPP encoding keeps the old mode
  function automatic logic [31:0] mstatus_wr(input logic [31:0] old_v,
                                             input logic [31:0] d);
    logic [31:0] v;
    v = d & MSTATUS_WR_MASK;
    if (d[MSTATUS_MPP_LO +: 2] == PRIVILEG_RESERVED)
      v[MSTATUS_MPP_LO +: 2] = old_v[MSTATUS_MPP_LO +: 2];
    return v;
  endfunction

  function automatic logic [31:0] align4(input logic [31:0] d);
    return {d[31:2], 2'b00};
  endfunction

  // Clint has priority; the execute write is dropped on collision
  always_comb begin
    wr_en   = clint_wr_en_i | ex_wr_en_i;
    wr_addr = clint_wr_en_i ? clint_wr_addr_i[11:0] : ex_wr_addr_i[11:0];
    wr_data = clint_wr_en_i ? clint_wr_data_i : ex_wr_data_i;
  end

  // Value the winning write will commit, masked, for storage and forwarding
  always_comb begin
    fwd_ok  = 1'b1;
    fwd_val = '0;
    case (wr_addr)
      CSR_MSTATUS:  fwd_val = mstatus_wr(mstatus_q, wr_data);
      CSR_MIE:      fwd_val = wr_data & MIE_WR_MASK;
      CSR_MTVEC:    fwd_val = align4(wr_data);
      CSR_MEPC:     fwd_val = align4(wr_data);
      CSR_MSCRATCH: fwd_val = wr_data;
      CSR_MCAUSE:   fwd_val = wr_data;
`ifdef CSR_CYCLE_COUNTER_EN
      CSR_MCYCLE:   fwd_val = wr_data;
      CSR_MCYCLEH:  fwd_val = wr_data;
`endif
      default:      fwd_ok = 1'b0;
    endcase
  end

  // Forwarding is suppressed in reset so reads show reset contents
  assign fwd_hit = rst_n & wr_en & fwd_ok;

  // CSR storage; async reset discards any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS:  mstatus_q  <= fwd_val;
        CSR_MIE:      mie_q      <= fwd_val;
        CSR_MTVEC:    mtvec_q    <= fwd_val;
        CSR_MSCRATCH: mscratch_q <= fwd_val;
        CSR_MEPC:     mepc_q     <= fwd_val;
        CSR_MCAUSE:   mcause_q   <= fwd_val;
        default: ;
      endcase
    end
  end

  // Privilege level from clint; the reserved encoding is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      priv_q <= PRIVILEG_MACHINE;
    else if (wr_privilege_en_i && wr_privilege_i != PRIVILEG_RESERVED)
      priv_q <= wr_privilege_i;
  end

`ifdef CSR_CYCLE_COUNTER_EN
  csr_counter64 u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_lo_i   (wr_en && wr_addr == CSR_MCYCLE),
    .load_hi_i   (wr_en && wr_addr == CSR_MCYCLEH),
    .load_data_i (wr_data),
    .count_o     (cycle_q)
  );
`else
  assign cycle_q = '0;
`endif

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [11:0] ra;
    logic [31:0] rd_val;
    assign ra = (p == 0) ? ex_rd_addr_i[11:0] : clint_rd_addr_i[11:0];
    // Read mux with same-cycle forwarding of the winning write
    always_comb begin
      rd_val = '0;
      case (ra)
        CSR_MSTATUS:  rd_val = mstatus_q;
        CSR_MISA:     rd_val = MISA_VALUE;
        CSR_MIE:      rd_val = mie_q;
        CSR_MTVEC:    rd_val = mtvec_q;
        CSR_MSCRATCH: rd_val = mscratch_q;
        CSR_MEPC:     rd_val = mepc_q;
        CSR_MCAUSE:   rd_val = mcause_q;
        CSR_MCYCLE:   rd_val = cycle_q[31:0];
        CSR_MCYCLEH:  rd_val = cycle_q[63:32];
        CSR_CYCLE:    rd_val = cycle_q[31:0];
        CSR_CYCLEH:   rd_val = cycle_q[63:32];
        default:      rd_val = '0;
      endcase
      if (fwd_hit && wr_addr == ra)
        rd_val = fwd_val;
    end
  end

  assign ex_rd_data_o    = g_rd[0].rd_val;
  assign clint_rd_data_o = g_rd[1].rd_val;
  assign privilege_o     = priv_q;
  assign csr_mtvec_o     = mtvec_q;
  assign csr_mepc_o      = mepc_q;
  assign csr_mstatus_o   = mstatus_q;
  assign global_int_en_o = mstatus_q[MSTATUS_MIE_BIT];

endmodule
